// File: rtl/bcd_convert_seq_if.sv
// Valid/ready handshake bundle for the sequential binary-to-BCD converter.
// master = producer/consumer side, slave = converter side.
interface bcd_convert_seq_if #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      in_bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic                  out_ovf;

    modport master (
        output in_valid, in_bin, out_ready,
        input  in_ready, out_valid, out_bcd, out_ovf
    );

    modport slave (
        input  in_valid, in_bin, out_ready,
        output in_ready, out_valid, out_bcd, out_ovf
    );
endinterface

// File: rtl/bcd_convert_seq.sv
// Multi-cycle double-dabble converter: one shift-add-3 iteration per clock,
// valid/ready on both sides, sticky overflow when the value exceeds DIGITS digits.
module bcd_convert_seq #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_convert_seq_if.slave   bus
);

    localparam int unsigned ACC_W = 4 * DIGITS;
    localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q;
    logic [BIN_W-1:0]   bin_q;
    logic [ACC_W-1:0]   acc_q;
    logic               ovf_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               out_valid_q;
    logic [ACC_W-1:0]   out_bcd_q;
    logic               out_ovf_q;

    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   acc_shift;
    logic [BIN_W-1:0]   bin_shift;
    logic               ovf_next;
    logic               last_iter;

    // Add-3 on every digit >= 5, all digits judged from the pre-adjust value.
    always_comb begin
        acc_adj = acc_q;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (acc_q[4*k +: 4] >= 4'd5) begin
                acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
            end
        end
    end

    assign acc_shift = {acc_adj[ACC_W-2:0], bin_q[BIN_W-1]};
    assign bin_shift = bin_q << 1;
    assign ovf_next  = ovf_q | acc_adj[ACC_W-1];
    assign last_iter = (cnt_q == CNT_W'(BIN_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_bcd_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        bin_q   <= bus.in_bin;
                        acc_q   <= '0;
                        ovf_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q <= acc_shift;
                    bin_q <= bin_shift;
                    ovf_q <= ovf_next;
                    if (last_iter) begin
                        out_bcd_q   <= acc_shift;
                        out_ovf_q   <= ovf_next;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    // Result held indefinitely until the consumer takes it.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_bcd   = out_bcd_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Self-checking bench for bcd_convert_seq in three configurations (8/3, 8/2, 16/5)
// with an accept-time scoreboard per instance.
module tb_bcd_convert_seq;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    bcd_convert_seq_if #(.BIN_W(8),  .DIGITS(3)) b0();
    bcd_convert_seq_if #(.BIN_W(8),  .DIGITS(2)) b1();
    bcd_convert_seq_if #(.BIN_W(16), .DIGITS(5)) b2();

    bcd_convert_seq #(.BIN_W(8),  .DIGITS(3)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    bcd_convert_seq #(.BIN_W(8),  .DIGITS(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    bcd_convert_seq #(.BIN_W(16), .DIGITS(5)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    // Reference: {ovf, 5 BCD digits} of v truncated to 'digits' digits.
    function automatic logic [20:0] ref_bcd(input int unsigned v, input int unsigned digits);
        logic [19:0]  b;
        int unsigned  t;
        b = '0;
        t = v;
        for (int i = 0; i < int'(digits); i++) begin
            b[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return {(t != 0), b};
    endfunction

    logic [20:0] sb0[$];
    logic [20:0] sb1[$];
    logic [20:0] sb2[$];

    // Expected results enter the scoreboards at the accepting edge.
    always @(posedge clk) begin
        if (rst_n && b0.in_valid && b0.in_ready) sb0.push_back(ref_bcd(32'(b0.in_bin), 3));
        if (rst_n && b1.in_valid && b1.in_ready) sb1.push_back(ref_bcd(32'(b1.in_bin), 2));
        if (rst_n && b2.in_valid && b2.in_ready) sb2.push_back(ref_bcd(32'(b2.in_bin), 5));
    end

    task automatic run0(input logic [7:0] v, input bit chk_lat, output logic [12:0] got);
        int n;
        logic [20:0] e;
        @(negedge clk);
        n = 0;
        while (!b0.in_ready && n < 100) begin @(negedge clk); n++; end
        b0.in_valid = 1'b1; b0.in_bin = v; b0.out_ready = 1'b1;
        @(posedge clk); #1;
        b0.in_valid = 1'b0; b0.in_bin = 8'($urandom);
        n = 0;
        while (!b0.out_valid && n < 64) begin @(posedge clk); #1; n++; end
        got = {b0.out_ovf, b0.out_bcd};
        checks++;
        if (!b0.out_valid) begin errors++; $display("FAIL run0_timeout: in=%0d out_valid=%b required 1", v, b0.out_valid); end
        if (chk_lat) begin
            checks++;
            if (n !== 8) begin errors++; $display("FAIL run0_latency: in=%0d got %0d cycles required 8", v, n); end
        end
        checks++;
        if (sb0.size() == 0) begin
            errors++; $display("FAIL run0_sb_empty: in=%0d got out=%h with nothing expected", v, got);
        end else begin
            e = sb0.pop_front();
            if (got !== {e[20], e[11:0]}) begin
                errors++; $display("FAIL run0_value: in=%0d got ovf/bcd=%h required %h", v, got, {e[20], e[11:0]});
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic run1(input logic [7:0] v, output logic [8:0] got);
        int n;
        logic [20:0] e;
        @(negedge clk);
        n = 0;
        while (!b1.in_ready && n < 100) begin @(negedge clk); n++; end
        b1.in_valid = 1'b1; b1.in_bin = v; b1.out_ready = 1'b1;
        @(posedge clk); #1;
        b1.in_valid = 1'b0;
        n = 0;
        while (!b1.out_valid && n < 64) begin @(posedge clk); #1; n++; end
        got = {b1.out_ovf, b1.out_bcd};
        checks++;
        if (!b1.out_valid || n !== 8) begin errors++; $display("FAIL run1_latency: in=%0d got %0d cycles required 8", v, n); end
        checks++;
        if (sb1.size() == 0) begin
            errors++; $display("FAIL run1_sb_empty: in=%0d got out=%h with nothing expected", v, got);
        end else begin
            e = sb1.pop_front();
            if (got !== {e[20], e[7:0]}) begin
                errors++; $display("FAIL run1_value: in=%0d got ovf/bcd=%h required %h", v, got, {e[20], e[7:0]});
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic run2(input logic [15:0] v, output logic [20:0] got);
        int n;
        logic [20:0] e;
        @(negedge clk);
        n = 0;
        while (!b2.in_ready && n < 100) begin @(negedge clk); n++; end
        b2.in_valid = 1'b1; b2.in_bin = v; b2.out_ready = 1'b1;
        @(posedge clk); #1;
        b2.in_valid = 1'b0;
        n = 0;
        while (!b2.out_valid && n < 64) begin @(posedge clk); #1; n++; end
        got = {b2.out_ovf, b2.out_bcd};
        checks++;
        if (!b2.out_valid || n !== 16) begin errors++; $display("FAIL run2_latency: in=%0d got %0d cycles required 16", v, n); end
        checks++;
        if (sb2.size() == 0) begin
            errors++; $display("FAIL run2_sb_empty: in=%0d got out=%h with nothing expected", v, got);
        end else begin
            e = sb2.pop_front();
            if (got !== e) begin
                errors++; $display("FAIL run2_value: in=%0d got ovf/bcd=%h required %h", v, got, e);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({b0.in_ready, b0.out_valid, b0.out_ovf, b0.out_bcd} !== {3'b100, 12'h000}) begin
            errors++; $display("FAIL reset_u0: got rdy/vld/ovf/bcd=%b%b%b/%h required 100/000",
                               b0.in_ready, b0.out_valid, b0.out_ovf, b0.out_bcd);
        end
        checks++;
        if ({b1.in_ready, b1.out_valid, b2.in_ready, b2.out_valid, b2.out_bcd} !== {4'b1010, 20'h0}) begin
            errors++; $display("FAIL reset_u1u2: got u1 rdy/vld=%b%b u2 rdy/vld=%b%b bcd=%h required 10 10 0",
                               b1.in_ready, b1.out_valid, b2.in_ready, b2.out_valid, b2.out_bcd);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_latency_255();
        logic [12:0] got;
        run0(8'd255, 1'b1, got);
        checks++;
        if (got !== 13'h0255) begin errors++; $display("FAIL max_255: got %h required 0255", got); end
        checks++;
        if (b0.in_ready !== 1'b1 || b0.out_valid !== 1'b0) begin
            errors++; $display("FAIL ready_after_done: got in_ready=%b out_valid=%b required 1 0", b0.in_ready, b0.out_valid);
        end
    endtask

    task automatic test_boundary();
        logic [12:0] got;
        logic [7:0]  vin [4] = '{8'd0, 8'd59, 8'd99, 8'd100};
        logic [12:0] vexp[4] = '{13'h0000, 13'h0059, 13'h0099, 13'h0100};
        for (int i = 0; i < 4; i++) begin
            run0(vin[i], 1'b1, got);
            checks++;
            if (got !== vexp[i]) begin errors++; $display("FAIL boundary: in=%0d got %h required %h", vin[i], got, vexp[i]); end
        end
    endtask

    task automatic test_sweep();
        logic [12:0] got;
        for (int v = 0; v < 256; v++) run0(8'(v), 1'b0, got);
    endtask

    task automatic test_backpressure();
        int n;
        logic [20:0] e;
        @(negedge clk);
        b0.out_ready = 1'b0; b0.in_valid = 1'b1; b0.in_bin = 8'd23;
        @(posedge clk); #1;
        b0.in_bin = 8'd77;
        n = 0;
        while (!b0.out_valid && n < 64) begin @(posedge clk); #1; n++; end
        checks++;
        if (n !== 8) begin errors++; $display("FAIL bp_latency: got %0d cycles required 8", n); end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({b0.out_valid, b0.in_ready, b0.out_ovf, b0.out_bcd} !== {3'b100, 12'h023} || sb0.size() !== 1) begin
                errors++; $display("FAIL bp_hold: cycle %0d got vld/rdy/ovf/bcd=%b%b%b/%h sb=%0d required 100/023 sb=1",
                                   c, b0.out_valid, b0.in_ready, b0.out_ovf, b0.out_bcd, sb0.size());
            end
        end
        e = sb0.pop_front();
        checks++;
        if ({b0.out_ovf, b0.out_bcd} !== {e[20], e[11:0]}) begin
            errors++; $display("FAIL bp_value: got %h required %h", {b0.out_ovf, b0.out_bcd}, {e[20], e[11:0]});
        end
        b0.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (b0.out_valid !== 1'b0 || b0.in_ready !== 1'b1 || sb0.size() !== 0) begin
            errors++; $display("FAIL bp_release: got out_valid=%b in_ready=%b sb=%0d required 0 1 0",
                               b0.out_valid, b0.in_ready, sb0.size());
        end
        @(posedge clk); #1;
        b0.in_valid = 1'b0;
        n = 0;
        while (!b0.out_valid && n < 64) begin @(posedge clk); #1; n++; end
        checks++;
        if (sb0.size() == 0) begin
            errors++; $display("FAIL bp_second_sb: got nothing accepted required 77 accepted");
        end else begin
            e = sb0.pop_front();
            if ({b0.out_ovf, b0.out_bcd} !== 13'h0077 || e[12:0] !== 13'h0077 || n !== 8) begin
                errors++; $display("FAIL bp_second: got %h after %0d cycles required 0077 after 8",
                                   {b0.out_ovf, b0.out_bcd}, n);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        logic [8:0] got;
        logic [7:0] vin [4] = '{8'd123, 8'd99, 8'd200, 8'd255};
        logic [8:0] vexp[4] = '{9'h123, 9'h099, 9'h100, 9'h155};
        for (int i = 0; i < 4; i++) begin
            run1(vin[i], got);
            checks++;
            if (got !== vexp[i]) begin errors++; $display("FAIL overflow: in=%0d got ovf/bcd=%h required %h", vin[i], got, vexp[i]); end
        end
    endtask

    task automatic test_wide();
        logic [20:0] got;
        logic [15:0] vin [3] = '{16'd65535, 16'd2025, 16'd1};
        logic [20:0] vexp[3] = '{21'h065535, 21'h002025, 21'h000001};
        for (int i = 0; i < 3; i++) begin
            run2(vin[i], got);
            checks++;
            if (got !== vexp[i]) begin errors++; $display("FAIL wide: in=%0d got %h required %h", vin[i], got, vexp[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [12:0] got;
        @(negedge clk);
        b0.in_valid = 1'b1; b0.in_bin = 8'd200; b0.out_ready = 1'b1;
        @(posedge clk); #1;
        b0.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({b0.out_valid, b0.in_ready, b0.out_ovf, b0.out_bcd} !== {3'b010, 12'h000}) begin
            errors++; $display("FAIL reset_mid: got vld/rdy/ovf/bcd=%b%b%b/%h required 010/000",
                               b0.out_valid, b0.in_ready, b0.out_ovf, b0.out_bcd);
        end
        sb0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run0(8'd42, 1'b1, got);
        checks++;
        if (got !== 13'h0042) begin errors++; $display("FAIL after_reset: got %h required 0042", got); end
    endtask

    initial begin
        rst_n = 1'b0;
        b0.in_valid = 1'b0; b0.in_bin = '0; b0.out_ready = 1'b0;
        b1.in_valid = 1'b0; b1.in_bin = '0; b1.out_ready = 1'b0;
        b2.in_valid = 1'b0; b2.in_bin = '0; b2.out_ready = 1'b0;
        test_reset();
        test_latency_255();
        test_boundary();
        test_sweep();
        test_backpressure();
        test_overflow();
        test_wide();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bcd_convert_seq.md
Name: bcd_convert_seq

Overview:
Parametrised, multi-cycle binary-to-BCD converter. It is the sequential successor of the per-field double-dabble converters used by the RTC display path. It runs one shift-add-3 iteration per clock, so logic depth stays constant for any width. It uses valid/ready handshakes on input and output, and flags values that do not fit in the configured digit count. Typical use: one instance time-shared across the RTC fields (sec/min/hour/day/month/year), or wide counters (e.g. 16-bit year/day-of-year) feeding display logic.

Parameters:
BIN_W, 8, binary input width in bits (>=1)
DIGITS, 3, number of BCD output digits (>=1); out_bcd is 4*DIGITS bits

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  in_bin holds a value to convert
in_ready  out  1  converter can accept a value (high only in IDLE)
in_bin  in  BIN_W  unsigned binary input
out_valid  out  1  out_bcd/out_ovf hold a completed result
out_ready  in  1  consumer accepts result
out_bcd  out  4*DIGITS  packed BCD result; digit k at bits [4k+3:4k], k=0 is units
out_ovf  out  1  value >= 10^DIGITS; out_bcd then holds value mod 10^DIGITS

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, out_valid=0, out_bcd=0, out_ovf=0, iteration counter=0, internal shift/BCD registers=0. in_ready reads 1 while in reset, because it is decoded from state=IDLE.
- Reset mid-conversion: aborts immediately. No result is produced and the partial value is discarded.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1.
  - If in_valid=1 at a rising edge, capture in_bin into the binary shift register, clear the BCD accumulator, clear the sticky ovf, set count=0, go to SHIFT.
  - If in_valid=0, stay in IDLE.
- SHIFT: in_ready=0. Each cycle performs one iteration:
  - every accumulator digit >=5 gets +3 (4-bit add, all digits evaluated from the pre-adjust value in parallel);
  - then {accumulator, binary reg} shifts left by 1;
  - the MSB shifted out of the top digit ORs into sticky ovf;
  - count increments.
- SHIFT exit: after exactly BIN_W iterations (count reaches BIN_W-1 on the last one), load out_bcd and out_ovf from the final accumulator and sticky ovf, set out_valid=1, go to DONE.
- Latency: if accepted at edge E0, iterations occur at edges E1..E_BIN_W. out_valid is visible after edge E_BIN_W. Accept-to-valid = BIN_W cycles.
- DONE: out_valid=1, in_ready=0.
  - out_bcd and out_ovf are held stable while out_ready=0; backpressure is unbounded.
  - On an edge with out_valid&&out_ready, clear out_valid and go to IDLE.
  - A new input is not accepted in the same cycle. Minimum initiation interval = BIN_W+2 cycles.
- Output hold: out_bcd and out_ovf keep the last result after the handshake until the next DONE entry. They change only on SHIFT->DONE.
- in_bin is sampled only at the accepting edge. Later changes have no effect.
- Width rules: the accumulator is 4*DIGITS bits and is not widened.
  - Overflow: any 1 shifted out of the top digit => out_ovf=1. The remaining digits are then exactly value mod 10^DIGITS.
  - No overflow is possible when 10^DIGITS > 2^BIN_W-1.
- BIN_W=1 degenerates correctly: 1 iteration, result 0 or 1.
- Every out_bcd digit is always in 0..9.

Test Plan:
1. BIN_W=8, DIGITS=3, in_bin=255 with out_ready=1 -> out_valid exactly 8 cycles after accept; out_bcd=12'h255, out_ovf=0; in_ready back to 1 on the next cycle.
2. Boundary/sweep, BIN_W=8, DIGITS=3: in_bin=0 -> 12'h000; 59 -> 12'h059; 99 -> 12'h099; 100 -> 12'h100. Exhaustive 0..255 checked against a reference model.
3. Backpressure: convert 23 with out_ready=0 for 20 cycles -> out_valid stays 1, out_bcd=12'h023 stable, in_ready=0. Raise out_ready for 1 cycle -> out_valid=0, IDLE. in_valid held high throughout is not accepted until IDLE.
4. Overflow, BIN_W=8, DIGITS=2: in_bin=123 -> out_bcd=8'h23, out_ovf=1. Then in_bin=99 -> out_bcd=8'h99, out_ovf=0 (sticky flag cleared per conversion).
5. Wide config, BIN_W=16, DIGITS=5: in_bin=65535 -> out_bcd=20'h65535 after 16 cycles; in_bin=2025 -> 20'h02025.
6. Reset mid-operation: assert rst_n=0 asynchronously at iteration 4 of 8 -> out_valid=0, out_bcd=0, out_ovf=0 immediately, in_ready=1. After release, converting 42 -> 12'h042 with normal latency.
